// File: rtl/portal_teleport_ctrl.sv
// Portal teleport controller: latches per-frame ball/portal hits, issues a one-shot teleport
// command to the opposite portal, then ignores hits for a frame-counted cooldown. Macro: PORTAL_TELEPORT_COUNT_EN.
module portal_teleport_ctrl #(
   parameter int PORTAL_SIZE     = 32,
   parameter int BALL_SIZE       = 16,
   parameter int COOLDOWN_FRAMES = 30
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               collisionBlue,
   input  logic               collisionOrange,
   input  logic signed [10:0] topLeftXBlue,
   input  logic signed [10:0] topLeftYBlue,
   input  logic signed [10:0] topLeftXOrange,
   input  logic signed [10:0] topLeftYOrange,
   output logic               teleportValid,
   input  logic               teleportReady,
   output logic signed [10:0] teleportX,
   output logic signed [10:0] teleportY,
`ifdef PORTAL_TELEPORT_COUNT_EN
   output logic [7:0]         teleportCount,
`endif
   output logic               cooldownActive
);

   localparam logic signed [11:0] OFFSET  = 12'((PORTAL_SIZE - BALL_SIZE) / 2);
   localparam logic [7:0]         CD_LOAD = 8'(COOLDOWN_FRAMES);

   typedef enum logic [1:0] {IDLE, REQ, COOLDOWN} state_t;

   state_t             state, state_nxt;
   logic               hit_blue, hit_orange;
   logic               hit_blue_nxt, hit_orange_nxt;
   logic [7:0]         cnt, cnt_nxt;
   logic               load_dest, handshake;
   logic               any_blue, any_orange;
   logic signed [10:0] src_x, src_y;
   logic signed [10:0] exit_x, exit_y;

   // A strobe coinciding with startOfFrame still counts toward this frame's decision.
   assign any_blue   = hit_blue | collisionBlue;
   assign any_orange = hit_orange | collisionOrange;

   // Blue wins when both were hit, so the exit is orange in that case.
   assign src_x  = any_blue ? topLeftXOrange : topLeftXBlue;
   assign src_y  = any_blue ? topLeftYOrange : topLeftYBlue;
   assign exit_x = 11'(12'(src_x) + OFFSET);
   assign exit_y = 11'(12'(src_y) + OFFSET);

   always_comb begin
      state_nxt      = state;
      hit_blue_nxt   = 1'b0;
      hit_orange_nxt = 1'b0;
      cnt_nxt        = cnt;
      load_dest      = 1'b0;
      handshake      = 1'b0;
      case (state)
         IDLE: begin
            if (startOfFrame) begin
               if (any_blue || any_orange) begin
                  state_nxt = REQ;
                  load_dest = 1'b1;
               end
            end else begin
               hit_blue_nxt   = any_blue;
               hit_orange_nxt = any_orange;
            end
         end
         REQ: begin
            if (teleportReady) begin
               handshake = 1'b1;
               state_nxt = COOLDOWN;
               cnt_nxt   = CD_LOAD;
            end
         end
         COOLDOWN: begin
            if (startOfFrame) begin
               if (cnt <= 8'd1) begin
                  state_nxt = IDLE;
                  cnt_nxt   = 8'd0;
               end else begin
                  cnt_nxt = cnt - 8'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         hit_blue   <= 1'b0;
         hit_orange <= 1'b0;
         cnt        <= 8'd0;
         teleportX  <= '0;
         teleportY  <= '0;
      end else begin
         state      <= state_nxt;
         hit_blue   <= hit_blue_nxt;
         hit_orange <= hit_orange_nxt;
         cnt        <= cnt_nxt;
         if (load_dest) begin
            teleportX <= exit_x;
            teleportY <= exit_y;
         end
      end
   end

   assign teleportValid  = (state == REQ);
   assign cooldownActive = (state == COOLDOWN);

`ifdef PORTAL_TELEPORT_COUNT_EN
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         teleportCount <= 8'd0;
      end else if (handshake && teleportCount != 8'hFF) begin
         teleportCount <= teleportCount + 8'd1;
      end
   end
`endif

endmodule
